// File: rtl/gtrg_readout_seq.sv
// gtrg_readout_seq: drains the GTRG FIFO one event at a time.
// Per event: latch the head entry, header handshake, grant each flagged
// source in fixed priority (ALCT first, CFEB5 last) with a per-source timeout,
// trailer handshake, then a single-clock POP and a settling gap.
module gtrg_readout_seq #(
  parameter int unsigned TO_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HALT,
  input  logic        EMPTY_B,
  input  logic [16:0] DAVSOUT,
  input  logic [11:0] BXCOUNTOUT,
  input  logic [3:0]  CFEBBX,
  output logic        POP,
  output logic        HDR_VLD,
  input  logic        HDR_ACK,
  output logic [11:0] EVT_BX,
  output logic [3:0]  EVT_CFEBBX,
  output logic [6:0]  EVT_MASK,
  output logic [6:0]  GRANT,
  input  logic [6:0]  DONE,
  output logic        TRL_VLD,
  input  logic        TRL_ACK,
  output logic [6:0]  TOERR,
  output logic        BUSY,
  output logic [15:0] EVT_CNT
);

  localparam int unsigned NSRC  = 7;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_LATCH,
    S_HDR,
    S_SCAN,
    S_GNT,
    S_TRL,
    S_POP,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic                pop_q, pop_d;
  logic                hdr_vld_q, hdr_vld_d;
  logic                trl_vld_q, trl_vld_d;
  logic                busy_q, busy_d;
  logic [NSRC-1:0]     mask_q, mask_d;
  logic [NSRC-1:0]     pending_q, pending_d;
  logic [NSRC-1:0]     grant_q, grant_d;
  logic [NSRC-1:0]     toerr_q, toerr_d;
  logic [11:0]         bx_q, bx_d;
  logic [3:0]          cfebbx_q, cfebbx_d;
  logic [15:0]         evt_cnt_q, evt_cnt_d;
  logic [TO_WIDTH-1:0] timer_q, timer_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [NSRC-1:0]     pick_c;
  logic                done_hit_c;
  logic                to_hit_c;
  logic [NSRC-1:0]     head_mask_c;

  // CFEB/MOVLP/LCT info above the CFEB DAV bits is not used by the sequencer
  logic unused_davs;
  assign unused_davs = ^DAVSOUT[15:6];

  // Lowest set pending bit is the highest-priority source still owed a grant
  assign pick_c      = pending_q & (~pending_q + 7'd1);
  assign done_hit_c  = |(DONE & grant_q);
  assign to_hit_c    = (timer_q == TO_LAST);
  assign head_mask_c = {DAVSOUT[5:1], DAVSOUT[0], DAVSOUT[16]};

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (EMPTY_B && !HALT) state_d = S_SETTLE;
      S_SETTLE: state_d = S_LATCH;
      S_LATCH:  state_d = S_HDR;
      S_HDR:    if (HDR_ACK) state_d = S_SCAN;
      S_SCAN:   state_d = (pending_q == '0) ? S_TRL : S_GNT;
      S_GNT:    if (done_hit_c || to_hit_c) state_d = S_SCAN;
      S_TRL:    if (TRL_ACK) state_d = S_POP;
      S_POP:    state_d = S_GAP;
      S_GAP:    if (gap_q == GAP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and event datapath
  always_comb begin
    pop_d     = (state_d == S_POP);
    hdr_vld_d = (state_d == S_HDR);
    trl_vld_d = (state_d == S_TRL);
    busy_d    = (state_d != S_IDLE);
    mask_d    = mask_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    toerr_d   = toerr_q;
    bx_d      = bx_q;
    cfebbx_d  = cfebbx_q;
    evt_cnt_d = evt_cnt_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    case (state_q)
      S_LATCH: begin
        mask_d    = head_mask_c;
        pending_d = head_mask_c;
        bx_d      = BXCOUNTOUT;
        cfebbx_d  = CFEBBX;
        toerr_d   = '0;
      end
      S_SCAN: begin
        if (pending_q != '0) begin
          grant_d = pick_c;
          timer_d = '0;
        end
      end
      S_GNT: begin
        timer_d = timer_q + TO_WIDTH'(1);
        // DONE takes precedence over a timeout on the same clock
        if (done_hit_c) begin
          pending_d = pending_q & ~grant_q;
          grant_d   = '0;
        end else if (to_hit_c) begin
          toerr_d   = toerr_q | grant_q;
          pending_d = pending_q & ~grant_q;
          grant_d   = '0;
        end
      end
      S_POP: begin
        evt_cnt_d = evt_cnt_q + 16'd1;
        gap_d     = '0;
      end
      S_GAP: gap_d = gap_q + GAP_W'(1);
      default: ;
    endcase
  end

  // Output and datapath registers; reset abandons the event without a pop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pop_q     <= 1'b0;
      hdr_vld_q <= 1'b0;
      trl_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      mask_q    <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      toerr_q   <= '0;
      bx_q      <= '0;
      cfebbx_q  <= '0;
      evt_cnt_q <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
    end else begin
      pop_q     <= pop_d;
      hdr_vld_q <= hdr_vld_d;
      trl_vld_q <= trl_vld_d;
      busy_q    <= busy_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      toerr_q   <= toerr_d;
      bx_q      <= bx_d;
      cfebbx_q  <= cfebbx_d;
      evt_cnt_q <= evt_cnt_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  assign POP        = pop_q;
  assign HDR_VLD    = hdr_vld_q;
  assign TRL_VLD    = trl_vld_q;
  assign BUSY       = busy_q;
  assign EVT_MASK   = mask_q;
  assign GRANT      = grant_q;
  assign TOERR      = toerr_q;
  assign EVT_BX     = bx_q;
  assign EVT_CFEBBX = cfebbx_q;
  assign EVT_CNT    = evt_cnt_q;

endmodule

// File: tb/tb_gtrg_readout_seq.sv
// Testbench for gtrg_readout_seq: FIFO + handshake responder model, table
// vectors, hand-written corner sequences and randomized events.
module tb_gtrg_readout_seq;

  localparam int TMO = 200;
  localparam int GAP = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        HALT;
  logic        EMPTY_B;
  logic [16:0] DAVSOUT;
  logic [11:0] BXCOUNTOUT;
  logic [3:0]  CFEBBX;
  logic        POP;
  logic        HDR_VLD;
  logic        HDR_ACK;
  logic [11:0] EVT_BX;
  logic [3:0]  EVT_CFEBBX;
  logic [6:0]  EVT_MASK;
  logic [6:0]  GRANT;
  logic [6:0]  DONE;
  logic        TRL_VLD;
  logic        TRL_ACK;
  logic [6:0]  TOERR;
  logic        BUSY;
  logic [15:0] EVT_CNT;

  gtrg_readout_seq #(
    .TO_WIDTH (8),
    .TIMEOUT  (TMO),
    .GAP_CYC  (GAP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .HALT       (HALT),
    .EMPTY_B    (EMPTY_B),
    .DAVSOUT    (DAVSOUT),
    .BXCOUNTOUT (BXCOUNTOUT),
    .CFEBBX     (CFEBBX),
    .POP        (POP),
    .HDR_VLD    (HDR_VLD),
    .HDR_ACK    (HDR_ACK),
    .EVT_BX     (EVT_BX),
    .EVT_CFEBBX (EVT_CFEBBX),
    .EVT_MASK   (EVT_MASK),
    .GRANT      (GRANT),
    .DONE       (DONE),
    .TRL_VLD    (TRL_VLD),
    .TRL_ACK    (TRL_ACK),
    .TOERR      (TOERR),
    .BUSY       (BUSY),
    .EVT_CNT    (EVT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] davs;
    logic [11:0] bx;
    logic [3:0]  cb;
  } ent_t;

  typedef struct {
    logic [16:0] davs;
    logic [11:0] bx;
    logic [3:0]  cb;
    int          hd;
    int          td;
    int          dd;
    logic [6:0]  exp_mask;
    logic [6:0]  exp_toerr;
    int          exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Environment state
  ent_t       fifo[$];
  logic [6:0] spur;
  int         hdr_dly, trl_dly;
  int         dly[7];
  int         hdr_cnt, trl_cnt, gcnt;
  logic [6:0] prev_grant;
  int         pops, busy_cyc, cyc, last_pop_cyc, min_pop_gap;
  logic [6:0] glog[$];
  int         glen[$];
  logic [6:0] pop_masks[$];
  int         exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source-mask mapping: bit0 ALCT, bit1 TMB, bits 2..6 CFEB1..CFEB5
  function automatic logic [6:0] model_mask(input logic [16:0] d);
    logic [6:0] m;
    m[0] = d[16];
    m[1] = d[0];
    for (int i = 1; i <= 5; i++) m[i+1] = d[i];
    return m;
  endfunction

  function automatic int model_len(input int d);
    return (d < TMO) ? d : TMO;
  endfunction

  function automatic logic [6:0] model_toerr(input logic [6:0] m);
    logic [6:0] t;
    for (int i = 0; i < 7; i++) t[i] = m[i] && (dly[i] > TMO);
    return t;
  endfunction

  function automatic int model_busy(input logic [6:0] m);
    int b;
    b = 2 + hdr_dly + 1 + trl_dly + 1 + GAP;
    for (int i = 0; i < 7; i++) if (m[i]) b += 1 + model_len(dly[i]);
    return b;
  endfunction

  task automatic drive();
    HDR_ACK = HDR_VLD && (hdr_cnt >= hdr_dly);
    TRL_ACK = TRL_VLD && (trl_cnt >= trl_dly);
    DONE = spur;
    for (int i = 0; i < 7; i++) if (GRANT[i] && (gcnt == dly[i])) DONE[i] = 1'b1;
    if (fifo.size() != 0) begin
      EMPTY_B    = 1'b1;
      DAVSOUT    = fifo[0].davs;
      BXCOUNTOUT = fifo[0].bx;
      CFEBBX     = fifo[0].cb;
    end else begin
      EMPTY_B    = 1'b0;
      DAVSOUT    = '0;
      BXCOUNTOUT = '0;
      CFEBBX     = '0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (BUSY) busy_cyc++;
    if (POP) begin
      pops++;
      pop_masks.push_back(EVT_MASK);
      if (last_pop_cyc >= 0 && (cyc - last_pop_cyc) < min_pop_gap) min_pop_gap = cyc - last_pop_cyc;
      last_pop_cyc = cyc;
      if (fifo.size() != 0) fifo.delete(0);
    end
    if (GRANT != 7'd0) begin
      if (GRANT != prev_grant) begin
        glog.push_back(GRANT);
        glen.push_back(0);
      end
      glen[glen.size()-1] = glen[glen.size()-1] + 1;
      gcnt = glen[glen.size()-1];
    end else begin
      gcnt = 0;
    end
    prev_grant = GRANT;
    hdr_cnt = HDR_VLD ? hdr_cnt + 1 : 0;
    trl_cnt = TRL_VLD ? trl_cnt + 1 : 0;
    drive();
  endtask

  task automatic push(input logic [16:0] davs, input logic [11:0] bx, input logic [3:0] cb);
    ent_t e;
    e.davs = davs;
    e.bx   = bx;
    e.cb   = cb;
    fifo.push_back(e);
    drive();
  endtask

  task automatic clear_logs();
    glog.delete();
    glen.delete();
    pop_masks.delete();
    prev_grant   = '0;
    gcnt         = 0;
    busy_cyc     = 0;
    last_pop_cyc = -1;
    min_pop_gap  = 1000;
  endtask

  // Runs until one more POP has been seen and the sequencer is idle again
  task automatic run_event(input int budget, input string nm);
    int p0;
    int n;
    p0 = pops;
    n  = 0;
    while ((pops == p0 || BUSY) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_completes"}, 32'((pops == p0 + 1) && !BUSY), 32'd1);
  endtask

  task automatic check_grants(input string nm, input logic [6:0] m);
    int k;
    logic [6:0] oh;
    k = 0;
    chk({nm, "_ngrants"}, 32'(glog.size()), 32'($countones(m)));
    for (int i = 0; i < 7; i++) begin
      if (m[i]) begin
        oh = 7'b1 << i;
        if (k < glog.size()) begin
          chk($sformatf("%s_grant%0d_id", nm, k), 32'(glog[k]), 32'(oh));
          chk($sformatf("%s_grant%0d_len", nm, k), 32'(glen[k]), 32'(model_len(dly[i])));
        end
        k++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n;
    int   p0;
    logic [6:0] m;

    vecs[0] = '{17'h1_0005, 12'hABC, 4'h5, 1, 1, 3,   7'b0001011, 7'b0000000, 20};
    vecs[1] = '{17'h0_0000, 12'h123, 4'h1, 1, 1, 3,   7'b0000000, 7'b0000000, 8};
    vecs[2] = '{17'h0_003E, 12'h3C5, 4'hA, 2, 3, 1,   7'b1111100, 7'b0000000, 21};
    vecs[3] = '{17'h1_0000, 12'h7FF, 4'hF, 1, 1, 2,   7'b0000001, 7'b0000000, 11};
    vecs[4] = '{17'h0_0001, 12'h001, 4'h3, 1, 1, 255, 7'b0000010, 7'b0000010, 209};
    vecs[5] = '{17'h0_0001, 12'h800, 4'h8, 1, 1, 200, 7'b0000010, 7'b0000000, 209};
    vecs[6] = '{17'h0_FFC0, 12'h555, 4'h6, 1, 2, 3,   7'b0000000, 7'b0000000, 9};
    vecs[7] = '{17'h1_FFFF, 12'hFED, 4'hC, 1, 1, 1,   7'b1111111, 7'b0000000, 22};

    RST = 1'b1; HALT = 1'b0; EMPTY_B = 1'b0; DAVSOUT = '0; BXCOUNTOUT = '0;
    CFEBBX = '0; HDR_ACK = 1'b0; TRL_ACK = 1'b0; DONE = '0;
    spur = '0; hdr_dly = 1; trl_dly = 1;
    for (int i = 0; i < 7; i++) dly[i] = 3;
    hdr_cnt = 0; trl_cnt = 0; pops = 0; cyc = 0; exp_cnt = 0;
    clear_logs();

    // Reset state
    #12;
    chk("rst_ctrl", 32'({POP, HDR_VLD, TRL_VLD, BUSY, GRANT, TOERR, EVT_MASK}), 32'd0);
    chk("rst_data", {EVT_BX, EVT_CFEBBX, EVT_CNT}, 32'd0);
    #1 RST = 1'b0;

    // Idle with an empty FIFO
    p0 = pops;
    repeat (50) tick();
    chk("idle_pops", 32'(pops - p0), 32'd0);
    chk("idle_busy", 32'(busy_cyc), 32'd0);
    chk("idle_cnt", 32'(EVT_CNT), 32'd0);

    // Table-driven single events
    for (int v = 0; v < 8; v++) begin
      clear_logs();
      hdr_dly = vecs[v].hd;
      trl_dly = vecs[v].td;
      for (int i = 0; i < 7; i++) dly[i] = vecs[v].dd;
      push(vecs[v].davs, vecs[v].bx, vecs[v].cb);
      run_event(1000, $sformatf("tbl%0d", v));
      exp_cnt++;
      chk($sformatf("tbl%0d_mask", v), 32'(EVT_MASK), 32'(vecs[v].exp_mask));
      chk($sformatf("tbl%0d_toerr", v), 32'(TOERR), 32'(vecs[v].exp_toerr));
      chk($sformatf("tbl%0d_bx", v), 32'(EVT_BX), 32'(vecs[v].bx));
      chk($sformatf("tbl%0d_cfebbx", v), 32'(EVT_CFEBBX), 32'(vecs[v].cb));
      chk($sformatf("tbl%0d_busy", v), 32'(busy_cyc), 32'(vecs[v].exp_busy));
      chk($sformatf("tbl%0d_cnt", v), 32'(EVT_CNT), 32'(exp_cnt));
      check_grants($sformatf("tbl%0d", v), vecs[v].exp_mask);
    end

    // Spurious DONE[6] while CFEB1 is granted
    clear_logs();
    hdr_dly = 1; trl_dly = 1;
    for (int i = 0; i < 7; i++) dly[i] = 4;
    spur = 7'b1000000;
    push(17'h0_0002, 12'h0F0, 4'h2);
    run_event(500, "spur");
    exp_cnt++;
    spur = '0;
    drive();
    check_grants("spur", 7'b0000100);
    chk("spur_toerr", 32'(TOERR), 32'd0);
    chk("spur_busy", 32'(busy_cyc), 32'd13);

    // Back-to-back entries with HALT raised during event 2
    clear_logs();
    for (int i = 0; i < 7; i++) dly[i] = 2;
    p0 = pops;
    push(17'h0_0001, 12'h101, 4'h1);
    push(17'h1_0000, 12'h202, 4'h2);
    push(17'h0_0020, 12'h303, 4'h3);
    n = 0;
    while (pops < p0 + 1 && n < 500) begin tick(); n++; end
    n = 0;
    while (GRANT == 7'd0 && n < 100) begin tick(); n++; end
    chk("b2b_ev2_grant", 32'(GRANT), 32'h1);
    HALT = 1'b1;
    n = 0;
    while ((pops < p0 + 2 || BUSY) && n < 500) begin tick(); n++; end
    chk("b2b_ev2_pops", 32'(pops - p0), 32'd2);
    busy_cyc = 0;
    repeat (30) tick();
    chk("halt_busy", 32'(busy_cyc), 32'd0);
    chk("halt_fifo", 32'(fifo.size()), 32'd1);
    HALT = 1'b0;
    n = 0;
    while ((pops < p0 + 3 || BUSY) && n < 500) begin tick(); n++; end
    exp_cnt += 3;
    chk("b2b_pops", 32'(pops - p0), 32'd3);
    chk("b2b_cnt", 32'(EVT_CNT), 32'(exp_cnt));
    chk("b2b_gap_ok", 32'(min_pop_gap >= GAP + 2), 32'd1);
    chk("b2b_npopmask", 32'(pop_masks.size()), 32'd3);
    if (pop_masks.size() == 3) begin
      chk("b2b_mask0", 32'(pop_masks[0]), 32'h02);
      chk("b2b_mask1", 32'(pop_masks[1]), 32'h01);
      chk("b2b_mask2", 32'(pop_masks[2]), 32'h40);
    end

    // Randomized events against the model
    for (int e = 0; e < 25; e++) begin
      logic [16:0] rd;
      logic [11:0] rb;
      logic [3:0]  rc;
      int          r;
      clear_logs();
      rd = 17'($urandom);
      rb = 12'($urandom);
      rc = 4'($urandom);
      hdr_dly = int'($urandom_range(1, 3));
      trl_dly = int'($urandom_range(1, 3));
      for (int i = 0; i < 7; i++) begin
        r = int'($urandom_range(0, 15));
        if (r == 0)      dly[i] = 255;
        else if (r == 1) dly[i] = TMO;
        else             dly[i] = int'($urandom_range(1, 6));
      end
      push(rd, rb, rc);
      run_event(3000, $sformatf("rnd%0d", e));
      exp_cnt++;
      m = model_mask(rd);
      chk($sformatf("rnd%0d_mask", e), 32'(EVT_MASK), 32'(m));
      chk($sformatf("rnd%0d_toerr", e), 32'(TOERR), 32'(model_toerr(m)));
      chk($sformatf("rnd%0d_bx", e), 32'(EVT_BX), 32'(rb));
      chk($sformatf("rnd%0d_cfebbx", e), 32'(EVT_CFEBBX), 32'(rc));
      chk($sformatf("rnd%0d_busy", e), 32'(busy_cyc), 32'(model_busy(m)));
      chk($sformatf("rnd%0d_cnt", e), 32'(EVT_CNT), 32'(exp_cnt));
      check_grants($sformatf("rnd%0d", e), m);
    end

    // Asynchronous reset in the middle of a grant
    clear_logs();
    hdr_dly = 1; trl_dly = 1;
    for (int i = 0; i < 7; i++) dly[i] = 3;
    dly[1] = 255;
    push(17'h0_0001, 12'h9A9, 4'h7);
    n = 0;
    while (GRANT == 7'd0 && n < 100) begin tick(); n++; end
    chk("rstgnt_grant", 32'(GRANT), 32'h2);
    repeat (5) tick();
    #2 RST = 1'b1;
    #1;
    chk("rstgnt_ctrl", 32'({POP, HDR_VLD, TRL_VLD, BUSY, GRANT, TOERR, EVT_MASK}), 32'd0);
    chk("rstgnt_data", {EVT_BX, EVT_CFEBBX, EVT_CNT}, 32'd0);
    #2 RST = 1'b0;
    clear_logs();
    dly[1] = 3;
    drive();
    exp_cnt = 0;
    run_event(500, "rstgnt_rerun");
    exp_cnt++;
    chk("rstgnt_cnt", 32'(EVT_CNT), 32'(exp_cnt));
    chk("rstgnt_fifo", 32'(fifo.size()), 32'd0);
    chk("rstgnt_bx", 32'(EVT_BX), 32'h9A9);
    check_grants("rstgnt", 7'b0000010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
